// File: rtl/fall_alarm_responder.sv
// fall_alarm_responder: confirms a fall after CONFIRM_N consecutive valid
// over-threshold samples, raises a latched alarm until acknowledged, then
// ignores samples for COOLDOWN_CYC cycles before re-arming.
// Optional build macro: FALL_ALARM_EVENT_COUNT_EN adds the saturating
// event_count output (number of confirmed falls since reset).
module fall_alarm_responder #(
    parameter int unsigned CONFIRM_N    = 4,
    parameter int unsigned COOLDOWN_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [7:0] sensor_value,
    input  logic [7:0] factory_value,
    input  logic       alarm_ack,
    output logic       alarm,
    output logic       alarm_pulse,
    output logic       busy
`ifdef FALL_ALARM_EVENT_COUNT_EN
    ,
    output logic [7:0] event_count
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StConfirm,
        StAlarm,
        StCooldown
    } stateE;

    // Widened so a run length of 255 compares without overflow.
    localparam logic [8:0]  ConfirmTarget = 9'(CONFIRM_N);
    localparam logic [15:0] CoolInit      = 16'(COOLDOWN_CYC);

    stateE       state;
    logic [7:0]  hitCnt;
    logic [15:0] coolCnt;
    logic        hit;
    logic [8:0]  hitNext;
    logic        enterAlarm;

    // Equality with the threshold counts as a hit.
    assign hit     = sample_valid & (sensor_value >= factory_value);
    assign hitNext = {1'b0, hitCnt} + 9'd1;

    // Decode the edge on which the confirming hit is sampled.
    always_comb begin
        enterAlarm = 1'b0;
        if (hit) begin
            if (state == StIdle) begin
                enterAlarm = (CONFIRM_N == 1);
            end else if (state == StConfirm) begin
                enterAlarm = (hitNext == ConfirmTarget);
            end
        end
    end

    // Main FSM with registered alarm, alarm_pulse and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            hitCnt      <= 8'd0;
            coolCnt     <= 16'd0;
            alarm       <= 1'b0;
            alarm_pulse <= 1'b0;
            busy        <= 1'b0;
        end else begin
            alarm_pulse <= 1'b0;
            if (enterAlarm) begin
                state       <= StAlarm;
                hitCnt      <= 8'd0;
                alarm       <= 1'b1;
                alarm_pulse <= 1'b1;
                busy        <= 1'b1;
            end else begin
                case (state)
                    StIdle: begin
                        if (hit) begin
                            state  <= StConfirm;
                            hitCnt <= 8'd1;
                            busy   <= 1'b1;
                        end
                    end
                    StConfirm: begin
                        if (hit) begin
                            hitCnt <= hitNext[7:0];
                        end else if (sample_valid) begin
                            // A valid miss breaks the run; gaps do not.
                            state  <= StIdle;
                            hitCnt <= 8'd0;
                            busy   <= 1'b0;
                        end
                    end
                    StAlarm: begin
                        // Samples are ignored; only the ack matters here.
                        if (alarm_ack) begin
                            alarm <= 1'b0;
                            if (COOLDOWN_CYC == 0) begin
                                state <= StIdle;
                                busy  <= 1'b0;
                            end else begin
                                state   <= StCooldown;
                                coolCnt <= CoolInit;
                            end
                        end
                    end
                    StCooldown: begin
                        // Counting N..1 gives a dwell of exactly N cycles.
                        if (coolCnt <= 16'd1) begin
                            state   <= StIdle;
                            coolCnt <= 16'd0;
                            busy    <= 1'b0;
                        end else begin
                            coolCnt <= coolCnt - 16'd1;
                        end
                    end
                    default: begin
                        state  <= StIdle;
                        hitCnt <= 8'd0;
                        alarm  <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FALL_ALARM_EVENT_COUNT_EN
    // Saturating count of confirmed falls, updated with alarm_pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            event_count <= 8'd0;
        end else if (enterAlarm && (event_count != 8'hFF)) begin
            event_count <= event_count + 8'd1;
        end
    end
`endif

endmodule
